// File: rtl/adc_result_fifo.sv
// adc_result_fifo: captures ADC results on strobe rising edges into a FWFT FIFO with a sticky overflow flag; define ADC_RESULT_FIFO_SYNC_EN for a 2-flop strobe synchronizer
module adc_result_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_in,
  input  logic                       conv_finished_in,
  input  logic [DATA_WIDTH-1:0]      result_in,
  input  logic                       rd_ready_in,
  output logic                       rd_valid_out,
  output logic [DATA_WIDTH-1:0]      rd_data_out,
  output logic [$clog2(DEPTH):0]     fill_level_out,
  output logic                       overflow_out,
  input  logic                       clear_overflow_in
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic s2_d, s2, s3, wr_req, pop, full, wr_en;
`ifdef ADC_RESULT_FIFO_SYNC_EN
  logic s1;
  always_ff @(posedge clk)
    if (rst) s1 <= 1'b1;
    else s1 <= conv_finished_in;
  assign s2_d = s1;
`else
  assign s2_d = conv_finished_in;
`endif
  always_ff @(posedge clk)
    if (rst) {s2, s3} <= 2'b11;
    else {s2, s3} <= {s2_d, s2};
  assign wr_req       = s2 & ~s3 & enable_in;
  assign full         = fill_level_out == (AW+1)'(DEPTH);
  assign rd_valid_out = fill_level_out != '0;
  assign pop          = rd_valid_out & rd_ready_in;
  assign wr_en        = wr_req & (~full | pop);
  assign rd_data_out  = rd_valid_out ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= result_in;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level_out <= '0;
      overflow_out   <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr + AW'(wr_en);
      rd_ptr         <= rd_ptr + AW'(pop);
      fill_level_out <= fill_level_out + (AW+1)'(wr_en) - (AW+1)'(pop);
      overflow_out   <= (wr_req & full & ~pop) | (overflow_out & ~clear_overflow_in);
    end
endmodule

// File: tb/tb_adc_result_fifo.sv
// tb_adc_result_fifo: directed and random checks of adc_result_fifo against a queue model
module tb_adc_result_fifo;
  localparam int DEPTH = 8;
`ifdef ADC_RESULT_FIFO_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  logic clk = 0, rst, enable_in, conv_finished_in, rd_ready_in, clear_overflow_in;
  logic [15:0] result_in, rd_data_out;
  logic rd_valid_out, overflow_out;
  logic [3:0] fill_level_out;
  logic [15:0] q[$];
  logic movf;
  logic [2:0] h;
  int nvec = 0, nerr = 0;

  adc_result_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable_in(enable_in), .conv_finished_in(conv_finished_in),
    .result_in(result_in), .rd_ready_in(rd_ready_in), .rd_valid_out(rd_valid_out),
    .rd_data_out(rd_data_out), .fill_level_out(fill_level_out), .overflow_out(overflow_out),
    .clear_overflow_in(clear_overflow_in));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model: a write fires when the strobe, delayed by L samples, shows a 0->1 step
  task automatic step();
    logic wr, pp, ovs;
    @(posedge clk);
    if (rst) begin
      q.delete();
      movf = 0;
      h = 3'b111;
    end else begin
      wr  = enable_in & h[L-1] & ~h[L];
      pp  = q.size() != 0 && rd_ready_in;
      ovs = wr && q.size() == DEPTH && !pp;
      if (pp) void'(q.pop_front());
      if (wr && !ovs) q.push_back(result_in);
      movf = ovs | (movf & ~clear_overflow_in);
      h = {h[1:0], conv_finished_in};
    end
    #1;
    check("valid", rd_valid_out, q.size() != 0);
    check("data", rd_data_out, q.size() != 0 ? q[0] : 16'h0);
    check("level", fill_level_out, q.size());
    check("ovf", overflow_out, movf);
  endtask

  task automatic strobe(input logic [15:0] d);
    result_in = d;
    conv_finished_in = 1;
    step();
    conv_finished_in = 0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1; enable_in = 1; conv_finished_in = 1; result_in = 0;
    rd_ready_in = 0; clear_overflow_in = 0; movf = 0; h = 3'b111;
    repeat (2) step();
    rst = 0;
    repeat (3) step();
    check("rst_level", fill_level_out, 0);
    check("rst_valid", rd_valid_out, 0);
    check("rst_ovf", overflow_out, 0);
    conv_finished_in = 0;
    step();

    strobe(16'h0123); strobe(16'h0456); strobe(16'h0789);
    check("three_level", fill_level_out, 3);
    check("three_head", rd_data_out, 16'h0123);
    rd_ready_in = 1;
    step(); check("pop1", rd_data_out, 16'h0456);
    step(); check("pop2", rd_data_out, 16'h0789);
    step(); check("pop3_valid", rd_valid_out, 0); check("pop3_data", rd_data_out, 0);
    step();
    rd_ready_in = 0;

    for (int i = 0; i <= DEPTH; i++) strobe(16'h1000 + 16'(i));
    check("ovf_level", fill_level_out, DEPTH);
    check("ovf_set", overflow_out, 1);
    rd_ready_in = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_order", rd_data_out, 16'h1000 + 16'(i));
      step();
    end
    check("ovf_drained", rd_valid_out, 0);
    rd_ready_in = 0;
    check("ovf_sticky", overflow_out, 1);
    clear_overflow_in = 1; step(); clear_overflow_in = 0;
    check("ovf_clear", overflow_out, 0);

    for (int i = 0; i < DEPTH; i++) strobe(16'h2000 + 16'(i));
    result_in = 16'h2ABC;
    conv_finished_in = 1;
    repeat (L) step();
    rd_ready_in = 1; step(); rd_ready_in = 0;
    conv_finished_in = 0;
    step();
    check("fullpop_level", fill_level_out, DEPTH);
    check("fullpop_ovf", overflow_out, 0);
    rd_ready_in = 1;
    repeat (DEPTH - 1) step();
    check("fullpop_last", rd_data_out, 16'h2ABC);
    step();
    rd_ready_in = 0;

    result_in = 16'h3333;
    conv_finished_in = 1;
    repeat (20) step();
    conv_finished_in = 0;
    step();
    check("hold_one", fill_level_out, 1);
    rd_ready_in = 1; step(); rd_ready_in = 0;
    enable_in = 0;
    strobe(16'h4444);
    enable_in = 1;
    repeat (2) step();
    check("dis_level", fill_level_out, 0);
    check("dis_ovf", overflow_out, 0);

    result_in = 16'h5555;
    conv_finished_in = 1;
    step();
    repeat (L - 1) step();
    check("lat_early", rd_valid_out, 0);
    step();
    check("lat_valid", rd_valid_out, 1);
    conv_finished_in = 0;
    rd_ready_in = 1; step(); rd_ready_in = 0;

    for (int i = 0; i < 1500; i++) begin
      logic nc;
      nc = ($urandom_range(3) == 0) ? ~conv_finished_in : conv_finished_in;
      if (nc && !conv_finished_in) result_in = 16'($urandom);
      conv_finished_in = nc;
      enable_in = $urandom_range(9) != 0;
      rd_ready_in = $urandom_range(3) == 0;
      clear_overflow_in = $urandom_range(15) == 0;
      rst = $urandom_range(199) == 0;
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/adc_result_fifo.md
Name: adc_result_fifo

Overview:
- Downstream consumer of the ADC digital core's `result_out` / `conv_finished_out` pair.
- Detects each conversion-finished strobe, captures the 16-bit result and buffers it in a small first-word-fall-through FIFO.
- Results are drained through a valid/ready read port by the SoC-side register/bus interface.
- Tracks fill level and a sticky overflow flag, so slow readout loses no samples silently.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- DATA_WIDTH, 16, width of `result_in` and `rd_data_out`.

Ports:
- clk  input  1  block clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- enable_in  input  1  1 = capture results; 0 = ignore strobes (the read side keeps working).
- conv_finished_in  input  1  conversion-finished strobe from the ADC core; the rising edge marks new data.
- result_in  input  DATA_WIDTH  conversion result; held stable by the core until the next strobe.
- rd_ready_in  input  1  consumer accepts `rd_data_out` this cycle.
- rd_valid_out  output  1  FIFO non-empty; `rd_data_out` is valid.
- rd_data_out  output  DATA_WIDTH  head-of-FIFO word; 0 when empty.
- fill_level_out  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- overflow_out  output  1  sticky: a capture was dropped because the FIFO was full.
- clear_overflow_in  input  1  synchronous clear of `overflow_out`.

Behaviour:
- Reset (`rst` = 1 at a clk edge):
  - read/write pointers = 0, `fill_level_out` = 0, `rd_valid_out` = 0, `rd_data_out` = 0, `overflow_out` = 0.
  - strobe pipeline registers `s1`, `s2`, `s3` = 1; this prevents a false edge if `conv_finished_in` is already high or low when reset releases.
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- Strobe path, with the synchronizer (see Optional Feature):
  - `s1` <= `conv_finished_in`, `s2` <= `s1`, `s3` <= `s2`.
  - `wr_req` = `s2` & ~`s3` & `enable_in`.
- Latency: input rises before edge k -> `wr_req` high after edge k+1 -> word written and `rd_valid_out` = 1 after edge k+2.
- Data capture: `result_in` is sampled at the write edge, not at the strobe edge.
- One write per rising edge: a strobe held high for many cycles produces exactly one entry.
- Read (FWFT):
  - `rd_data_out` = `mem[rd_ptr]` whenever `rd_valid_out` = 1.
  - Pop occurs at the clk edge where `rd_valid_out` & `rd_ready_in`.
  - `rd_ready_in` while empty has no effect.
- Pointers: `log2(DEPTH)` bits, natural wrap-around.
- `fill_level_out` is registered: +1 on write-only, -1 on pop-only, unchanged on simultaneous write and pop.
- Full (level = DEPTH) with `wr_req`:
  - If a pop occurs the same cycle, both happen; no overflow, level stays DEPTH.
  - Otherwise the new sample is dropped, the old contents are kept and `overflow_out` <= 1.
- Empty with `wr_req` and `rd_ready_in`: no bypass; the word becomes visible the next cycle.
- `clear_overflow_in`: clears `overflow_out`; if a new overflow occurs in the same cycle, set wins (`overflow_out` = 1).
- `enable_in` deassertion:
  - The strobe pipeline still runs, so re-enable never creates a false edge.
  - A strobe whose edge falls while disabled is lost.
  - Stored data is unaffected.

Optional Feature:
- Macro: `ADC_RESULT_FIFO_SYNC_EN`.
- Defined:
  - 2-flop synchronizer `s1`/`s2` on `conv_finished_in`, used when the ADC clock is asynchronous to `clk`.
  - Write latency is edge k+2 as above.
  - `result_in` is quasi-static and is not synchronized; its stability is guaranteed by the core's hold-until-next-strobe behaviour.
- Not defined:
  - `s1` is removed and `s2` <= `conv_finished_in` directly.
  - Write latency is edge k+1; the input must be synchronous to `clk`.

Test Plan:
- Reset with `conv_finished_in` held high, then release -> no write, `fill_level_out` = 0, `rd_valid_out` = 0.
- Three strobes with `result_in` = 0x0123, 0x0456, 0x0789, `rd_ready_in` = 0 -> `fill_level_out` = 3, `rd_data_out` = 0x0123. Then hold `rd_ready_in` = 1 -> pops 0x0123, 0x0456, 0x0789 on consecutive cycles, then `rd_valid_out` = 0 and `rd_data_out` = 0.
- DEPTH+1 strobes with no reads -> `fill_level_out` = DEPTH, `overflow_out` = 1, and DEPTH words read back in order with the last one dropped. Then pulse `clear_overflow_in` -> `overflow_out` = 0.
- Full FIFO, strobe edge in the same cycle as a pop -> level stays DEPTH, `overflow_out` stays 0, and the new word appears last.
- Strobe held high for 20 cycles -> exactly one entry. Strobe with `enable_in` = 0 -> no entry, no overflow.
- Latency check, run in both macro builds: strobe rises before edge k -> `rd_valid_out` = 1 after edge k+2 with the macro, after edge k+1 without it.
